// File: rtl/gate_tt_checker.sv
// gate_tt_checker
//   Scores strobed (A, B, Y) samples from a 2-input gate under test against
//   a parameterised truth table. It tracks input-combination coverage,
//   saturating sample and error counts, and captures the first failure.
//
// Parameters
//   TRUTH_TABLE  expected Y per input combination, bit index {A,B}
//                (default 4'b0001 = NOR)
//   CNT_W        width of sample_count / err_count (2..16)
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   clear          synchronous soft clear, same effect as rst
//   sample_valid   score A/B/Y this cycle
//   A, B, Y        gate inputs and the observed gate output
//   covered        bit {A,B} set once that combination has been sampled
//   sample_count   scored samples (saturating)
//   err_count      mismatching samples (saturating)
//   err_flag       sticky mismatch flag
//   first_err_idx  {A,B} of the first mismatch
//   first_err_y    observed Y of the first mismatch
//   done           all four combinations covered (state FULL)
//   pass           done with no mismatch seen
module gate_tt_checker #(
  parameter logic [3:0] TRUTH_TABLE = 4'b0001,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic             A,
  input  logic             B,
  input  logic             Y,
  output logic [3:0]       covered,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_flag,
  output logic [1:0]       first_err_idx,
  output logic             first_err_y,
  output logic             done,
  output logic             pass
);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [3:0]       covered_q, covered_d;
  logic [CNT_W-1:0] sample_count_q, sample_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             err_flag_q, err_flag_d;
  logic [1:0]       first_err_idx_q, first_err_idx_d;
  logic             first_err_y_q, first_err_y_d;

  logic [1:0] idx;
  logic       exp_y;
  logic       mismatch;
  logic [3:0] covered_next;

  assign idx          = {A, B};
  assign exp_y        = TRUTH_TABLE[idx];
  assign mismatch     = sample_valid && (Y != exp_y);
  assign covered_next = covered_q | (4'b0001 << idx);

  always_comb begin
    // NOTE: every signal gets a default hold value first so no path through
    // this block leaves a variable unassigned (which would infer a latch).
    state_d         = state_q;
    covered_d       = covered_q;
    sample_count_d  = sample_count_q;
    err_count_d     = err_count_q;
    err_flag_d      = err_flag_q;
    first_err_idx_d = first_err_idx_q;
    first_err_y_d   = first_err_y_q;

    if (clear) begin
      // A sample coincident with clear is discarded.
      state_d         = ST_EMPTY;
      covered_d       = 4'b0000;
      sample_count_d  = '0;
      err_count_d     = '0;
      err_flag_d      = 1'b0;
      first_err_idx_d = 2'b00;
      first_err_y_d   = 1'b0;
    end else if (sample_valid) begin
      covered_d = covered_next;
      if (sample_count_q != CNT_MAX) sample_count_d = sample_count_q + CNT_W'(1);

      if (mismatch) begin
        if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_W'(1);
        err_flag_d = 1'b1;
        // Capture only the very first failure; later ones leave it intact.
        if (!err_flag_q) begin
          first_err_idx_d = idx;
          first_err_y_d   = Y;
        end
      end

      case (state_q)
        ST_EMPTY:   state_d = ST_PARTIAL;
        ST_PARTIAL: if (covered_next == 4'b1111) state_d = ST_FULL;
        ST_FULL:    state_d = ST_FULL;
        default:    state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_EMPTY;
      covered_q       <= 4'b0000;
      sample_count_q  <= '0;
      err_count_q     <= '0;
      err_flag_q      <= 1'b0;
      first_err_idx_q <= 2'b00;
      first_err_y_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      covered_q       <= covered_d;
      sample_count_q  <= sample_count_d;
      err_count_q     <= err_count_d;
      err_flag_q      <= err_flag_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_y_q   <= first_err_y_d;
    end
  end

  assign covered       = covered_q;
  assign sample_count  = sample_count_q;
  assign err_count     = err_count_q;
  assign err_flag      = err_flag_q;
  assign first_err_idx = first_err_idx_q;
  assign first_err_y   = first_err_y_q;
  assign done          = (state_q == ST_FULL);
  assign pass          = done && !err_flag_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// tb_gate_tt_checker
//   Directed bench for gate_tt_checker. Two instances share the stimulus:
//   u_nor uses the default NOR table with 8-bit counters, u_and uses an AND
//   table with 2-bit counters for the saturation case. Outputs are sampled
//   1 time unit after the rising edge; inputs change on the falling edge.
module tb_gate_tt_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic sample_valid = 1'b0;
  logic A = 1'b0;
  logic B = 1'b0;
  logic Y = 1'b0;

  logic [3:0] n_covered;
  logic [7:0] n_sample_count, n_err_count;
  logic       n_err_flag, n_first_err_y, n_done, n_pass;
  logic [1:0] n_first_err_idx;

  logic [3:0] a_covered;
  logic [1:0] a_sample_count, a_err_count;
  logic       a_err_flag, a_first_err_y, a_done, a_pass;
  logic [1:0] a_first_err_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_tt_checker u_nor (
    .clk(clk), .rst(rst), .clear(clear), .sample_valid(sample_valid),
    .A(A), .B(B), .Y(Y),
    .covered(n_covered), .sample_count(n_sample_count), .err_count(n_err_count),
    .err_flag(n_err_flag), .first_err_idx(n_first_err_idx),
    .first_err_y(n_first_err_y), .done(n_done), .pass(n_pass)
  );

  gate_tt_checker #(.TRUTH_TABLE(4'b1000), .CNT_W(2)) u_and (
    .clk(clk), .rst(rst), .clear(clear), .sample_valid(sample_valid),
    .A(A), .B(B), .Y(Y),
    .covered(a_covered), .sample_count(a_sample_count), .err_count(a_err_count),
    .err_flag(a_err_flag), .first_err_idx(a_first_err_idx),
    .first_err_y(a_first_err_y), .done(a_done), .pass(a_pass)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One scored sample: drive on the falling edge, return just after the rising edge.
  task automatic sample(input logic a, input logic b, input logic y);
    @(negedge clk);
    sample_valid = 1'b1; A = a; B = b; Y = y;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
  endtask

  // Every u_nor output against its reset value.
  task automatic check_nor_zero(input string tag);
    check({tag, ".covered"},  32'(n_covered), 32'h0);
    check({tag, ".scount"},   32'(n_sample_count), 32'h0);
    check({tag, ".ecount"},   32'(n_err_count), 32'h0);
    check({tag, ".eflag"},    32'(n_err_flag), 32'h0);
    check({tag, ".fidx"},     32'(n_first_err_idx), 32'h0);
    check({tag, ".fy"},       32'(n_first_err_y), 32'h0);
    check({tag, ".done"},     32'(n_done), 32'h0);
    check({tag, ".pass"},     32'(n_pass), 32'h0);
  endtask

  initial begin
    // Reset state
    pulse_rst();
    check_nor_zero("reset");
    check("reset.and_covered", 32'(a_covered), 32'h0);

    // Good NOR gate, one sample per combination
    sample(1'b0, 1'b0, 1'b1); check("nor.cov1", 32'(n_covered), 32'h1);
    check("nor.done1", 32'(n_done), 32'h0);
    sample(1'b0, 1'b1, 1'b0); check("nor.cov2", 32'(n_covered), 32'h3);
    sample(1'b1, 1'b0, 1'b0); check("nor.cov3", 32'(n_covered), 32'h7);
    check("nor.done3", 32'(n_done), 32'h0);
    sample(1'b1, 1'b1, 1'b0); check("nor.cov4", 32'(n_covered), 32'hf);
    check("nor.done4", 32'(n_done), 32'h1);
    check("nor.pass4", 32'(n_pass), 32'h1);
    check("nor.scount", 32'(n_sample_count), 32'd4);
    check("nor.ecount", 32'(n_err_count), 32'd0);

    // Faulty gate against the NOR table
    pulse_clear();
    check_nor_zero("clear1");
    sample(1'b0, 1'b0, 1'b0);
    check("flt.eflag1", 32'(n_err_flag), 32'h1);
    check("flt.fidx1", 32'(n_first_err_idx), 32'h0);
    check("flt.fy1", 32'(n_first_err_y), 32'h0);
    check("flt.ecount1", 32'(n_err_count), 32'd1);
    sample(1'b1, 1'b1, 1'b1);
    check("flt.fidx2", 32'(n_first_err_idx), 32'h0);
    check("flt.fy2", 32'(n_first_err_y), 32'h0);
    check("flt.ecount2", 32'(n_err_count), 32'd2);
    sample(1'b0, 1'b1, 1'b0);
    sample(1'b1, 1'b0, 1'b0);
    check("flt.ecount4", 32'(n_err_count), 32'd2);
    check("flt.scount4", 32'(n_sample_count), 32'd4);
    check("flt.done4", 32'(n_done), 32'h1);
    check("flt.pass4", 32'(n_pass), 32'h0);
    check("flt.fidx4", 32'(n_first_err_idx), 32'h0);
    check("flt.fy4", 32'(n_first_err_y), 32'h0);

    // AND table, 2-bit counters: saturation at 3
    pulse_rst();
    check("and.rst_ecount", 32'(a_err_count), 32'd0);
    for (int i = 0; i < 5; i++) sample(1'b1, 1'b1, 1'b0);
    check("and.ecount", 32'(a_err_count), 32'd3);
    check("and.scount", 32'(a_sample_count), 32'd3);
    check("and.covered", 32'(a_covered), 32'h8);
    check("and.done", 32'(a_done), 32'h0);
    check("and.eflag", 32'(a_err_flag), 32'h1);
    check("and.fidx", 32'(a_first_err_idx), 32'h3);
    check("and.fy", 32'(a_first_err_y), 32'h0);
    check("and.pass", 32'(a_pass), 32'h0);
    // Same samples are correct for NOR: coverage grows, no errors
    check("nor_sh.covered", 32'(n_covered), 32'h8);
    check("nor_sh.scount", 32'(n_sample_count), 32'd5);
    check("nor_sh.ecount", 32'(n_err_count), 32'd0);

    // Reach FULL with an error (mismatch on the completing sample), then
    // clear together with a sample
    pulse_clear();
    sample(1'b0, 1'b1, 1'b0);
    sample(1'b1, 1'b0, 1'b0);
    sample(1'b1, 1'b1, 1'b0);
    sample(1'b0, 1'b0, 1'b0);
    check("fe.done", 32'(n_done), 32'h1);
    check("fe.pass", 32'(n_pass), 32'h0);
    check("fe.ecount", 32'(n_err_count), 32'd1);
    check("fe.fidx", 32'(n_first_err_idx), 32'h0);
    @(negedge clk);
    clear = 1'b1; sample_valid = 1'b1; A = 1'b0; B = 1'b0; Y = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0; sample_valid = 1'b0;
    check_nor_zero("clr_sv");

    // rst in PARTIAL, then one sample
    sample(1'b0, 1'b0, 1'b1);
    sample(1'b0, 1'b1, 1'b0);
    check("rp.covered", 32'(n_covered), 32'h3);
    pulse_rst();
    check_nor_zero("rp_rst");
    sample(1'b1, 1'b1, 1'b0);
    check("rp.covered2", 32'(n_covered), 32'h8);
    check("rp.scount", 32'(n_sample_count), 32'd1);
    check("rp.done", 32'(n_done), 32'h0);
    check("rp.ecount", 32'(n_err_count), 32'd0);

    // Back-to-back samples with repeats
    pulse_clear();
    sample(1'b0, 1'b0, 1'b1);
    sample(1'b0, 1'b0, 1'b1);
    sample(1'b0, 1'b0, 1'b1);
    check("b2b.cov3", 32'(n_covered), 32'h1);
    check("b2b.scount3", 32'(n_sample_count), 32'd3);
    sample(1'b0, 1'b1, 1'b0);
    sample(1'b1, 1'b0, 1'b0);
    check("b2b.done5", 32'(n_done), 32'h0);
    sample(1'b1, 1'b1, 1'b0);
    check("b2b.done6", 32'(n_done), 32'h1);
    check("b2b.pass6", 32'(n_pass), 32'h1);
    check("b2b.scount6", 32'(n_sample_count), 32'd6);
    check("b2b.cov6", 32'(n_covered), 32'hf);

    // FULL is absorbing: a repeat keeps done and still counts
    sample(1'b0, 1'b0, 1'b1);
    check("abs.done", 32'(n_done), 32'h1);
    check("abs.scount", 32'(n_sample_count), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
